mor1kx_insn_encoder: RTL and testbench
======================================

// Module: mor1kx_insn_encoder
// PURPOSE
// - Inverse of the decode stage. Takes structured instruction requests and emits 32-bit ORBIS32 instruction words.
// - A request carries a format class, an opcode/sub-op, register indices and an immediate.
// - Sits in front of the debug instruction-injection path and the self-test stimulus generator.
// - Expands the 32-bit load-immediate pseudo-op into l.movhi + l.ori.
// - Output words are buffered in a small FIFO with a valid/ready handshake.
// PARAMETERS
// - DEPTH    4    output FIFO entries; must be a power of 2 and >= 2.
// PORTS
// - clk          in   1   single clock; all logic is rising-edge.
// - rst          in   1   synchronous, active-high reset.
// - req_valid_i  in   1   request present.
// - req_ready_o  out  1   request accepted when valid and ready are both high.
// - req_fmt_i    in   3   enc_fmt_t: R, I, S, J, SF, SFI, SHI, LI32.
// - req_opc_i    in   6   primary opcode (opc_t); ignored for R/SF/SFI/SHI/LI32.
// - req_sub_i    in   4   ALU/comp opcode; for SHI, sub[1:0] is the secondary shift opcode.
// - req_rd_i     in   5   rD.
// - req_ra_i     in   5   rA.
// - req_rb_i     in   5   rB.
// - req_imm_i    in   32  immediate: imm16 in [15:0], J offset in [25:0], shamt in [5:0], LI32 uses the full word.
// - insn_valid_o out  1   FIFO head valid.
// - insn_ready_i in   1   consumer takes the head word.
// - insn_o       out  32  encoded instruction.
// - insn_last_o  out  1   word is the final word of its request.
// - err_o        out  1   one-cycle pulse on an illegal request (macro only; tied 0 otherwise).
// BEHAVIOUR
// - Reset values: insn_valid_o=0, insn_o=0, insn_last_o=0, err_o=0. The FIFO is empty and the FSM is in IDLE.
// - req_ready_o is low while rst is high.
// - req_ready_o = (state==IDLE) && !fifo_full. It has no combinational dependence on insn_ready_i.
// - Latency: a word pushed in cycle N is visible on insn_* in cycle N+1. The FIFO is registered, not fall-through.
// - Field layout: op[31:26], rD[25:21], rA[20:16], rB[15:11].
//   - R: opc 0x38; sub in [3:0]; bits[10:4]=0.
//   - I: req_opc_i, rD, rA, imm[15:0].
//   - S (stores, mtspr): imm[15:11] goes to [25:21]; rA, rB; imm[10:0] goes to [10:0].
//   - J: opc, imm[25:0].
//   - SF: opc 0x39; [25]=0; sub in [24:21]; rA, rB; [10:0]=0.
//   - SFI: opc 0x2F; sub in [24:21]; rA; imm16.
//   - SHI: opc 0x2E; rD, rA; sub[1:0] in [7:6]; imm[5:0] in [5:0]; other bits 0.
// - LI32 expansion, with hi = imm[31:16] and lo = imm[15:0]:
//   - hi==0: a single l.ori rD,r0,lo.
//   - lo==0: a single l.movhi rD,hi. When both hi and lo are 0 this case wins, giving one movhi with value 0.
//   - otherwise: l.movhi rD,hi is pushed in the accept cycle and the FSM goes IDLE->EXPAND.
//   - In EXPAND, l.ori rD,rD,lo is pushed in the first cycle with !fifo_full (a pop in the same cycle counts), then back to IDLE.
//   - The saved rD/lo are held in registers during EXPAND.
// - insn_last_o=1 on every word except the movhi of a two-word LI32.
// - Simultaneous push and pop when full is legal and keeps the count unchanged.
// - Pop when empty is ignored.
// - Pointers are log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty on wrap.
// - rst high in any state, including mid-EXPAND, flushes the FIFO and drops the pending ori. Nothing partial is emitted.
// CONFIGURATION
// - MOR1KX_INSN_ENC_CHECK_EN defined: a request is illegal if any of these hold:
//   - J offset does not fit signed 26 bits (imm[31:25] not all equal);
//   - I/S/SFI imm[31:16] is neither all-0 nor all-1;
//   - SHI imm[31:6] is nonzero;
//   - I/J req_opc_i is not a member of opcodes_t for its class;
//   - req_fmt_i is undefined.
//   Illegal requests are still accepted (handshake completes), nothing is pushed, and err_o pulses the next cycle.
// - Not defined: no checks; out-of-range fields are truncated to their slot; err_o=0 constantly.
// STRUCTURE
// - Shared package mor1kx_pkg gains:
//   - enc_fmt_t enum;
//   - field LSB/width constants (OPC_LSB=26, RD_LSB=21, RA_LSB=16, RB_LSB=11, SHRT_SEC_LSB=6);
//   - enc_req_t struct.
// - It reuses opc_t, alu_opc_t and comp_opc_t.
// - Sub-module mor1kx_insn_enc_fifo: a DEPTH x 33 (insn+last) synchronous FIFO with full/empty flags.
// - The top level holds the combinational field packer and the IDLE/EXPAND FSM.
// TESTING
// - R: l.add r3,r1,r2 (fmt R, sub 0x0, rd3 ra1 rb2) -> 0xE0611000, last=1.
// - LI32 r4,0x12345678 -> 0x18801234 (last=0) then 0xA8845678 (last=1); req_ready_o low for exactly 1 cycle.
// - LI32 r5,0x000000FF -> single 0xA8A000FF. LI32 r5,0xABCD0000 -> single 0x18A0ABCD.
// - S: l.sw 8(r1),r2 -> 0xD4011008. J: l.j imm=0xFFFFFFFF -> 0x03FFFFFF.
// - DEPTH=4, insn_ready_i=0, 5 R requests -> 4 accepted and ready drops. Then insn_ready_i=1 -> words drain in order and the 5th is accepted.
// - Reset mid-EXPAND after 0x18801234 is pushed -> FIFO empty, no ori emitted. With CHECK_EN, J imm=0x02000000 -> err_o pulse, nothing pushed.

Source files
------------

// File: rtl/mor1kx_pkg.sv
// Shared mor1kx definitions: ORBIS32 opcodes, encoder formats, field layout
// and the encoder request payload. Used by mor1kx_insn_encoder and its FIFO.
package mor1kx_pkg;

  // Instruction and field geometry
  localparam int unsigned INSN_W       = 32;
  localparam int unsigned OPC_W        = 6;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned SUB_W        = 4;
  localparam int unsigned FMT_W        = 3;
  localparam int unsigned IMM16_W      = 16;
  localparam int unsigned JOFF_W       = 26;
  localparam int unsigned SHAMT_W      = 6;
  localparam int unsigned SHRT_SEC_W   = 2;

  localparam int unsigned OPC_LSB      = 26;
  localparam int unsigned RD_LSB       = 21;
  localparam int unsigned RA_LSB       = 16;
  localparam int unsigned RB_LSB       = 11;
  localparam int unsigned SHRT_SEC_LSB = 6;

  // Primary opcodes
  typedef enum logic [OPC_W-1:0] {
    OPC_J     = 6'h00,
    OPC_JAL   = 6'h01,
    OPC_BNF   = 6'h03,
    OPC_BF    = 6'h04,
    OPC_NOP   = 6'h05,
    OPC_MOVHI = 6'h06,
    OPC_SYSTRAPSYNC = 6'h08,
    OPC_RFE   = 6'h09,
    OPC_JR    = 6'h11,
    OPC_JALR  = 6'h12,
    OPC_LWZ   = 6'h21,
    OPC_LWS   = 6'h22,
    OPC_LBZ   = 6'h23,
    OPC_LBS   = 6'h24,
    OPC_LHZ   = 6'h25,
    OPC_LHS   = 6'h26,
    OPC_ADDI  = 6'h27,
    OPC_ADDIC = 6'h28,
    OPC_ANDI  = 6'h29,
    OPC_ORI   = 6'h2a,
    OPC_XORI  = 6'h2b,
    OPC_MULI  = 6'h2c,
    OPC_MFSPR = 6'h2d,
    OPC_SHRTI = 6'h2e,
    OPC_SFIMM = 6'h2f,
    OPC_MTSPR = 6'h30,
    OPC_SW    = 6'h35,
    OPC_SB    = 6'h36,
    OPC_SH    = 6'h37,
    OPC_ALU   = 6'h38,
    OPC_SF    = 6'h39
  } opc_t;

  // ALU sub-opcodes
  typedef enum logic [SUB_W-1:0] {
    ALU_ADD   = 4'h0,
    ALU_ADDC  = 4'h1,
    ALU_SUB   = 4'h2,
    ALU_AND   = 4'h3,
    ALU_OR    = 4'h4,
    ALU_XOR   = 4'h5,
    ALU_MUL   = 4'h6,
    ALU_SHRT  = 4'h8,
    ALU_DIV   = 4'h9,
    ALU_DIVU  = 4'ha,
    ALU_MULU  = 4'hb,
    ALU_EXTBH = 4'hc,
    ALU_EXTW  = 4'hd,
    ALU_CMOV  = 4'he,
    ALU_FFL1  = 4'hf
  } alu_opc_t;

  // Set-flag comparison sub-opcodes
  typedef enum logic [SUB_W-1:0] {
    COMP_EQ  = 4'h0,
    COMP_NE  = 4'h1,
    COMP_GTU = 4'h2,
    COMP_GEU = 4'h3,
    COMP_LTU = 4'h4,
    COMP_LEU = 4'h5,
    COMP_GTS = 4'ha,
    COMP_GES = 4'hb,
    COMP_LTS = 4'hc,
    COMP_LES = 4'hd
  } comp_opc_t;

  // Encoder request format classes
  typedef enum logic [FMT_W-1:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_J    = 3'd3,
    FMT_SF   = 3'd4,
    FMT_SFI  = 3'd5,
    FMT_SHI  = 3'd6,
    FMT_LI32 = 3'd7
  } enc_fmt_t;

  typedef enum logic {
    ENC_IDLE   = 1'b0,
    ENC_EXPAND = 1'b1
  } enc_state_t;

  // Encoder request payload
  typedef struct packed {
    enc_fmt_t           fmt;
    logic [OPC_W-1:0]   opc;
    logic [SUB_W-1:0]   sub;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [INSN_W-1:0]  imm;
  } enc_req_t;

  // l.movhi rD,k
  function automatic logic [INSN_W-1:0] mk_movhi(input logic [REG_W-1:0] rd,
                                                 input logic [IMM16_W-1:0] k);
    logic [INSN_W-1:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = OPC_MOVHI;
    w[RD_LSB +: REG_W]  = rd;
    w[IMM16_W-1:0]      = k;
    return w;
  endfunction

  // l.ori rD,rA,k
  function automatic logic [INSN_W-1:0] mk_ori(input logic [REG_W-1:0] rd,
                                               input logic [REG_W-1:0] ra,
                                               input logic [IMM16_W-1:0] k);
    logic [INSN_W-1:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = OPC_ORI;
    w[RD_LSB +: REG_W]  = rd;
    w[RA_LSB +: REG_W]  = ra;
    w[IMM16_W-1:0]      = k;
    return w;
  endfunction

  // Opcodes legal for the J (26-bit offset) format
  function automatic logic is_j_opc(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_J, OPC_JAL, OPC_BNF, OPC_BF: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Opcodes legal for the I (rD, rA, imm16) format
  function automatic logic is_i_opc(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_MOVHI, OPC_LWZ, OPC_LWS, OPC_LBZ, OPC_LBS, OPC_LHZ, OPC_LHS,
      OPC_ADDI, OPC_ADDIC, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_MULI,
      OPC_MFSPR: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mor1kx_insn_enc_fifo.sv
// Registered (non fall-through) FIFO holding encoded words plus their
// last-word flag. Extra pointer MSB separates full from empty on wrap.
module mor1kx_insn_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_fire;
  logic             push_fire;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_fire  = pop && !empty_c;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign push_fire = push && (!full_c || pop_fire);
  assign head_c    = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset flushes the contents
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mor1kx_insn_encoder.sv
// ORBIS32 instruction encoder: packs structured requests into 32-bit words,
// expands the LI32 pseudo-op into l.movhi + l.ori, and buffers the words in
// a small output FIFO. Optional request legality checking is enabled by
// defining MOR1KX_INSN_ENC_CHECK_EN.
module mor1kx_insn_encoder
  import mor1kx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_fmt_i,
  input  logic [5:0]  req_opc_i,
  input  logic [3:0]  req_sub_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_ra_i,
  input  logic [4:0]  req_rb_i,
  input  logic [31:0] req_imm_i,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  output logic [31:0] insn_o,
  output logic        insn_last_o,
  output logic        err_o
);

  localparam int unsigned FIFO_W = INSN_W + 1;

  enc_state_t          state_q;
  enc_state_t          state_d;
  enc_req_t            req_c;
  logic [INSN_W-1:0]   packed_c;
  logic                illegal_c;
  logic                accept_c;
  logic                pop_fire_c;
  logic                push_c;
  logic [FIFO_W-1:0]   push_data_c;
  logic [FIFO_W-1:0]   head_c;
  logic                full_c;
  logic                empty_c;
  logic                load_li_c;
  logic [IMM16_W-1:0]  hi_c;
  logic [IMM16_W-1:0]  lo_c;
  logic                li_split_c;
  logic [REG_W-1:0]    li_rd_q;
  logic [IMM16_W-1:0]  li_lo_q;
  logic                err_q;

  assign req_c = '{fmt: enc_fmt_t'(req_fmt_i), opc: req_opc_i, sub: req_sub_i,
                   rd: req_rd_i, ra: req_ra_i, rb: req_rb_i, imm: req_imm_i};

  assign hi_c        = req_c.imm[INSN_W-1:IMM16_W];
  assign lo_c        = req_c.imm[IMM16_W-1:0];
  assign li_split_c  = (hi_c != '0) && (lo_c != '0);

  // Ready depends only on registered state, never on the consumer side
  assign req_ready_o = !rst && (state_q == ENC_IDLE) && !full_c;
  assign accept_c    = req_valid_i && req_ready_o;
  assign pop_fire_c  = insn_ready_i && !empty_c;

  // Field packer for all single-word formats
  always_comb begin
    packed_c = '0;
    case (req_c.fmt)
      FMT_R: begin
        packed_c[OPC_LSB +: OPC_W] = OPC_ALU;
        packed_c[RD_LSB +: REG_W]  = req_c.rd;
        packed_c[RA_LSB +: REG_W]  = req_c.ra;
        packed_c[RB_LSB +: REG_W]  = req_c.rb;
        packed_c[SUB_W-1:0]        = req_c.sub;
      end
      FMT_I: begin
        packed_c[OPC_LSB +: OPC_W] = req_c.opc;
        packed_c[RD_LSB +: REG_W]  = req_c.rd;
        packed_c[RA_LSB +: REG_W]  = req_c.ra;
        packed_c[IMM16_W-1:0]      = lo_c;
      end
      FMT_S: begin
        packed_c[OPC_LSB +: OPC_W] = req_c.opc;
        packed_c[RD_LSB +: REG_W]  = req_c.imm[15:11];
        packed_c[RA_LSB +: REG_W]  = req_c.ra;
        packed_c[RB_LSB +: REG_W]  = req_c.rb;
        packed_c[10:0]             = req_c.imm[10:0];
      end
      FMT_J: begin
        packed_c[OPC_LSB +: OPC_W] = req_c.opc;
        packed_c[JOFF_W-1:0]       = req_c.imm[JOFF_W-1:0];
      end
      FMT_SF: begin
        packed_c[OPC_LSB +: OPC_W] = OPC_SF;
        packed_c[RD_LSB +: SUB_W]  = req_c.sub;
        packed_c[RA_LSB +: REG_W]  = req_c.ra;
        packed_c[RB_LSB +: REG_W]  = req_c.rb;
      end
      FMT_SFI: begin
        packed_c[OPC_LSB +: OPC_W] = OPC_SFIMM;
        packed_c[RD_LSB +: SUB_W]  = req_c.sub;
        packed_c[RA_LSB +: REG_W]  = req_c.ra;
        packed_c[IMM16_W-1:0]      = lo_c;
      end
      FMT_SHI: begin
        packed_c[OPC_LSB +: OPC_W]           = OPC_SHRTI;
        packed_c[RD_LSB +: REG_W]            = req_c.rd;
        packed_c[RA_LSB +: REG_W]            = req_c.ra;
        packed_c[SHRT_SEC_LSB +: SHRT_SEC_W] = req_c.sub[SHRT_SEC_W-1:0];
        packed_c[SHAMT_W-1:0]                = req_c.imm[SHAMT_W-1:0];
      end
      default: packed_c = '0;
    endcase
  end

`ifdef MOR1KX_INSN_ENC_CHECK_EN
  // Request legality: out-of-range immediates and class/opcode mismatches
  always_comb begin
    illegal_c = 1'b0;
    case (req_c.fmt)
      FMT_I: illegal_c = !((&hi_c) || (hi_c == '0)) || !is_i_opc(req_c.opc);
      FMT_S, FMT_SFI: illegal_c = !((&hi_c) || (hi_c == '0));
      FMT_J: illegal_c = !((&req_c.imm[31:25]) || (req_c.imm[31:25] == '0)) ||
                         !is_j_opc(req_c.opc);
      FMT_SHI: illegal_c = (req_c.imm[INSN_W-1:SHAMT_W] != '0);
      FMT_R, FMT_SF, FMT_LI32: illegal_c = 1'b0;
      default: illegal_c = 1'b1;
    endcase
  end
`else
  assign illegal_c = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ENC_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: only a two-word LI32 enters EXPAND
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENC_IDLE: begin
        if (accept_c && !illegal_c && (req_c.fmt == FMT_LI32) && li_split_c)
          state_d = ENC_EXPAND;
      end
      ENC_EXPAND: begin
        if (!full_c || pop_fire_c) state_d = ENC_IDLE;
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  // FSM outputs: FIFO push word and LI32 save strobe
  always_comb begin
    push_c      = 1'b0;
    push_data_c = '0;
    load_li_c   = 1'b0;
    case (state_q)
      ENC_IDLE: begin
        if (accept_c && !illegal_c) begin
          push_c = 1'b1;
          if (req_c.fmt == FMT_LI32) begin
            if (lo_c == '0) begin
              push_data_c = {1'b1, mk_movhi(req_c.rd, hi_c)};
            end else if (hi_c == '0) begin
              push_data_c = {1'b1, mk_ori(req_c.rd, REG_W'(0), lo_c)};
            end else begin
              push_data_c = {1'b0, mk_movhi(req_c.rd, hi_c)};
              load_li_c   = 1'b1;
            end
          end else begin
            push_data_c = {1'b1, packed_c};
          end
        end
      end
      ENC_EXPAND: begin
        if (!full_c || pop_fire_c) begin
          push_c      = 1'b1;
          push_data_c = {1'b1, mk_ori(li_rd_q, li_rd_q, li_lo_q)};
        end
      end
      default: ;
    endcase
  end

  // Hold rD and the low half across EXPAND
  always_ff @(posedge clk) begin
    if (rst) begin
      li_rd_q <= '0;
      li_lo_q <= '0;
    end else if (load_li_c) begin
      li_rd_q <= req_c.rd;
      li_lo_q <= lo_c;
    end
  end

  // One-cycle error pulse after an accepted illegal request
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept_c && illegal_c;
  end

  mor1kx_insn_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (insn_ready_i),
    .head_c    (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  assign insn_valid_o = !empty_c;
  assign insn_o       = head_c[INSN_W-1:0];
  assign insn_last_o  = head_c[INSN_W];
  assign err_o        = err_q;

endmodule

// File: tb/tb_mor1kx_insn_encoder.sv
// Directed self-checking bench for mor1kx_insn_encoder (DEPTH=4).
module tb_mor1kx_insn_encoder;
  import mor1kx_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_fmt_i;
  logic [5:0]  req_opc_i;
  logic [3:0]  req_sub_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_ra_i;
  logic [4:0]  req_rb_i;
  logic [31:0] req_imm_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] insn_o;
  logic        insn_last_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  mor1kx_insn_encoder #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_fmt_i    (req_fmt_i),
    .req_opc_i    (req_opc_i),
    .req_sub_i    (req_sub_i),
    .req_rd_i     (req_rd_i),
    .req_ra_i     (req_ra_i),
    .req_rb_i     (req_rb_i),
    .req_imm_i    (req_imm_i),
    .insn_valid_o (insn_valid_o),
    .insn_ready_i (insn_ready_i),
    .insn_o       (insn_o),
    .insn_last_o  (insn_last_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns at the falling edge after acceptance
  task automatic send(input string tag, input logic [2:0] fmt, input logic [5:0] opc,
                      input logic [3:0] sub, input logic [4:0] rd, input logic [4:0] ra,
                      input logic [4:0] rb, input logic [31:0] imm);
    int t;
    t = 0;
    req_fmt_i = fmt; req_opc_i = opc; req_sub_i = sub;
    req_rd_i = rd; req_ra_i = ra; req_rb_i = rb; req_imm_i = imm;
    req_valid_i = 1'b1;
    while (!req_ready_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_accept"}, 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  // Check the FIFO head, then pop it
  task automatic expect_word(input string tag, input logic [31:0] exp, input logic exp_last);
    int t;
    t = 0;
    while (!insn_valid_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, 32'(insn_valid_o), 32'd1);
    chk(tag, insn_o, exp);
    chk({tag, "_last"}, 32'(insn_last_o), 32'(exp_last));
    insn_ready_i = 1'b1;
    @(negedge clk);
    insn_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; insn_ready_i = 1'b0;
    req_fmt_i = '0; req_opc_i = '0; req_sub_i = '0;
    req_rd_i = '0; req_ra_i = '0; req_rb_i = '0; req_imm_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_valid", 32'(insn_valid_o), 32'd0);
    chk("rst_insn", insn_o, 32'h0);
    chk("rst_last", 32'(insn_last_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready_o), 32'd1);

    // R: l.add r3,r1,r2
    send("add", FMT_R, 6'h00, 4'h0, 5'd3, 5'd1, 5'd2, 32'h0);
    expect_word("add", 32'hE0611000, 1'b1);

    // LI32 two-word expansion, ready low for exactly one cycle
    send("li_split", FMT_LI32, 6'h00, 4'h0, 5'd4, 5'd0, 5'd0, 32'h12345678);
    chk("li_split_busy", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    chk("li_split_back", 32'(req_ready_o), 32'd1);
    expect_word("li_movhi", 32'h18801234, 1'b0);
    expect_word("li_ori", 32'hA8845678, 1'b1);

    // LI32 single-word cases
    send("li_lo", FMT_LI32, 6'h00, 4'h0, 5'd5, 5'd0, 5'd0, 32'h000000FF);
    expect_word("li_lo", 32'hA8A000FF, 1'b1);
    send("li_hi", FMT_LI32, 6'h00, 4'h0, 5'd5, 5'd0, 5'd0, 32'hABCD0000);
    expect_word("li_hi", 32'h18A0ABCD, 1'b1);
    send("li_zero", FMT_LI32, 6'h00, 4'h0, 5'd5, 5'd0, 5'd0, 32'h0);
    expect_word("li_zero", 32'h18A00000, 1'b1);
    chk("li_zero_drained", 32'(insn_valid_o), 32'd0);

    // Other formats
    send("sw", FMT_S, 6'h35, 4'h0, 5'd0, 5'd1, 5'd2, 32'h00000008);
    expect_word("sw", 32'hD4011008, 1'b1);
    send("j", FMT_J, 6'h00, 4'h0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    expect_word("j", 32'h03FFFFFF, 1'b1);
    send("addi", FMT_I, 6'h27, 4'h0, 5'd3, 5'd1, 5'd0, 32'hFFFFFFFF);
    expect_word("addi", 32'h9C61FFFF, 1'b1);
    send("sfeq", FMT_SF, 6'h00, 4'h0, 5'd0, 5'd1, 5'd2, 32'h0);
    expect_word("sfeq", 32'hE4011000, 1'b1);
    send("sfgtsi", FMT_SFI, 6'h00, 4'hA, 5'd0, 5'd3, 5'd0, 32'h00000005);
    expect_word("sfgtsi", 32'hBD430005, 1'b1);
    send("srli", FMT_SHI, 6'h00, 4'h1, 5'd3, 5'd4, 5'd0, 32'h00000007);
    expect_word("srli", 32'hB8640047, 1'b1);
    chk("err_quiet", 32'(err_o), 32'd0);

    // Fill the FIFO with the consumer stalled
    for (int i = 1; i <= 4; i++) begin
      send("fill", FMT_R, 6'h00, 4'h0, 5'(i), 5'd1, 5'd2, 32'h0);
    end
    req_fmt_i = FMT_R; req_rd_i = 5'd5; req_ra_i = 5'd1; req_rb_i = 5'd2;
    req_sub_i = 4'h0; req_valid_i = 1'b1;
    chk("full_ready", 32'(req_ready_o), 32'd0);
    chk("full_head", insn_o, 32'hE0211000);
    @(negedge clk);
    chk("full_hold", 32'(req_ready_o), 32'd0);
    insn_ready_i = 1'b1;
    @(negedge clk);
    chk("drain_w2", insn_o, 32'hE0411000);
    chk("drain_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("drain_w3", insn_o, 32'hE0611000);
    @(negedge clk);
    chk("drain_w4", insn_o, 32'hE0811000);
    @(negedge clk);
    chk("drain_w5", insn_o, 32'hE0A11000);
    chk("drain_w5_last", 32'(insn_last_o), 32'd1);
    @(negedge clk);
    chk("drain_empty", 32'(insn_valid_o), 32'd0);
    insn_ready_i = 1'b0;

    // Reset while the ori is still pending
    send("li_rst", FMT_LI32, 6'h00, 4'h0, 5'd4, 5'd0, 5'd0, 32'h12345678);
    chk("li_rst_movhi", insn_o, 32'h18801234);
    rst = 1'b1;
    @(negedge clk);
    chk("li_rst_flush", 32'(insn_valid_o), 32'd0);
    chk("li_rst_ready", 32'(req_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("li_rst_after", 32'(insn_valid_o), 32'd0);
    chk("li_rst_idle", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    chk("li_rst_no_ori", 32'(insn_valid_o), 32'd0);

    // Out-of-range J offset
    send("jbad", FMT_J, 6'h00, 4'h0, 5'd0, 5'd0, 5'd0, 32'h02000000);
`ifdef MOR1KX_INSN_ENC_CHECK_EN
    chk("jbad_err", 32'(err_o), 32'd1);
    chk("jbad_nopush", 32'(insn_valid_o), 32'd0);
    @(negedge clk);
    chk("jbad_err_pulse", 32'(err_o), 32'd0);
`else
    chk("jbad_err", 32'(err_o), 32'd0);
    expect_word("jbad_trunc", 32'h02000000, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
